// File: rtl/single_port_ram_pipelined_if.sv
// Request/response bundle for single_port_ram_pipelined: requester drives master, RAM implements slave.
// Widths are passed in so one interface type serves every RAM configuration.
interface single_port_ram_pipelined_if #(
    parameter int WIDTH         = 32,
    parameter int ADDRESS_WIDTH = 6,
    parameter int NUM_BYTES     = 4
);
    logic                     write_enable;
    logic [NUM_BYTES-1:0]     write_byte_enable;
    logic                     read_enable;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [WIDTH-1:0]         write_data;
    logic [WIDTH-1:0]         read_data;
    logic                     read_valid;
    logic                     clear_busy;
    logic                     read_parity_error;

    modport master (
        output write_enable, write_byte_enable, read_enable, address, write_data,
        input  read_data, read_valid, clear_busy, read_parity_error
    );

    modport slave (
        input  write_enable, write_byte_enable, read_enable, address, write_data,
        output read_data, read_valid, clear_busy, read_parity_error
    );
endinterface

// File: rtl/single_port_ram_pipelined.sv
// Single-port RAM with byte-lane writes, read pipeline and post-reset zeroing; optional per-lane parity via SINGLE_PORT_RAM_PIPELINED_PARITY_EN.
// Latency: read sampled at edge N is visible after edge N+READ_LATENCY-1, one request per cycle, in order.
// Backpressure: none; while clear_busy is high every request is silently dropped.
module single_port_ram_pipelined #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 64,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int BYTE_WIDTH    = 8,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_FIRST   = 0
) (
    input  logic                      clock,
    input  logic                      resetn,
    single_port_ram_pipelined_if.slave bus
);
    localparam int NUM_BYTES = WIDTH / BYTE_WIDTH;

    typedef enum logic {CLEARING, IDLE} state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] clr_cnt;
    logic                     clear_busy_q;

    logic [WIDTH-1:0]         mem [DEPTH];
    logic                     in_range;
    logic                     wr_acc;
    logic                     rd_acc;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]         mem_wdat;
    logic [NUM_BYTES-1:0]     mem_mask;
    logic [WIDTH-1:0]         old_word;
    logic [WIDTH-1:0]         rd_word;
    logic                     rd_perr;

    logic [READ_LATENCY-1:0]  pipe_vld;
    logic [READ_LATENCY-1:0]  pipe_perr;
    logic [WIDTH-1:0]         pipe_dat [READ_LATENCY];

    always_comb begin
        in_range = ({1'b0, bus.address} < (ADDRESS_WIDTH+1)'(DEPTH));
        wr_acc   = (state == IDLE) && bus.write_enable && in_range;
        rd_acc   = (state == IDLE) && bus.read_enable;
        // The clear sequencer owns the single write port until it finishes.
        mem_we   = (state == CLEARING) || wr_acc;
        mem_addr = (state == CLEARING) ? clr_cnt : bus.address;
        mem_wdat = (state == CLEARING) ? '0 : bus.write_data;
        mem_mask = (state == CLEARING) ? '1 : bus.write_byte_enable;
        old_word = in_range ? mem[bus.address] : '0;
        rd_word  = old_word;
        if ((WRITE_FIRST != 0) && wr_acc) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.write_byte_enable[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (mem_mask[i]) begin
                    mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdat[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

`ifdef SINGLE_PORT_RAM_PIPELINED_PARITY_EN
    logic [NUM_BYTES-1:0] par_mem [DEPTH];
    logic [NUM_BYTES-1:0] mem_wpar;
    logic [NUM_BYTES-1:0] old_par;
    logic [NUM_BYTES-1:0] rd_par;

    always_comb begin
        mem_wpar = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            mem_wpar[i] = ^mem_wdat[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        old_par = in_range ? par_mem[bus.address] : '0;
        rd_par  = old_par;
        // Freshly forwarded lanes carry their freshly computed parity.
        if ((WRITE_FIRST != 0) && wr_acc) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.write_byte_enable[i]) begin
                    rd_par[i] = mem_wpar[i];
                end
            end
        end
        rd_perr = 1'b0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            rd_perr = rd_perr | ((^rd_word[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ rd_par[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (mem_mask[i]) begin
                    par_mem[mem_addr][i] <= mem_wpar[i];
                end
            end
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= CLEARING;
            clr_cnt      <= '0;
            clear_busy_q <= 1'b1;
        end else begin
            unique case (state)
                CLEARING: begin
                    if (clr_cnt == ADDRESS_WIDTH'(DEPTH - 1)) begin
                        state        <= IDLE;
                        clear_busy_q <= 1'b0;
                    end
                    clr_cnt <= clr_cnt + ADDRESS_WIDTH'(1);
                end
                IDLE: begin
                    state        <= IDLE;
                    clear_busy_q <= 1'b0;
                end
                default: begin
                    state        <= CLEARING;
                    clr_cnt      <= '0;
                    clear_busy_q <= 1'b1;
                end
            endcase
        end
    end

    // Each stage only reloads data under a valid, so the last stage holds between responses.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pipe_vld  <= '0;
            pipe_perr <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_dat[k] <= '0;
            end
        end else begin
            pipe_vld[0]  <= rd_acc;
            pipe_perr[0] <= rd_acc && rd_perr;
            if (rd_acc) begin
                pipe_dat[0] <= rd_word;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_vld[k]  <= pipe_vld[k-1];
                pipe_perr[k] <= pipe_perr[k-1];
                if (pipe_vld[k-1]) begin
                    pipe_dat[k] <= pipe_dat[k-1];
                end
            end
        end
    end

    assign bus.read_data         = pipe_dat[READ_LATENCY-1];
    assign bus.read_valid        = pipe_vld[READ_LATENCY-1];
    assign bus.read_parity_error = pipe_perr[READ_LATENCY-1];
    assign bus.clear_busy        = clear_busy_q;
endmodule

// File: doc/single_port_ram_pipelined.md
Name: single_port_ram_pipelined

Overview:
Parametrised successor to the basic single-port RAM. One shared address port, with these additions:
- per-byte write enables
- configurable read latency with a read-valid pipeline
- selectable read-during-write mode
- hardware clear sequencer that zeroes the array after reset

It sits wherever buffers, tag/data arrays or scratchpads need a deterministic initial state without a software init loop.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of BYTE_WIDTH
DEPTH, 64, number of words; need not be a power of two
ADDRESS_WIDTH, CLOG2(DEPTH), address bus width
BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = WIDTH/BYTE_WIDTH
READ_LATENCY, 1, rising edges from request sample to data visible; legal 1..4
WRITE_FIRST, 0, read-during-write: 0 = return old data, 1 = return newly written data

Ports:
clock  input  1  clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
write_enable  input  1  write request this cycle
write_byte_enable  input  NUM_BYTES  byte lane mask for the write
read_enable  input  1  read request this cycle
address  input  ADDRESS_WIDTH  shared read/write address
write_data  input  WIDTH  write data
read_data  output  WIDTH  read data
read_valid  output  1  read_data carries a response this cycle
clear_busy  output  1  clear sequencer active; requests ignored
read_parity_error  output  1  parity mismatch on current response (see Optional Feature)

Behaviour:
- Reset (resetn low, asynchronous):
  - read_data = 0, read_valid = 0, read pipeline emptied, read_parity_error = 0.
  - clear_busy = 1, FSM = CLEARING, clear counter = 0.
  - Array contents are not reset asynchronously.
- FSM CLEARING:
  - Each rising edge writes all-zero (parity bits included) to address = counter, then increments the counter.
  - At counter = DEPTH-1 the write occurs and the FSM moves to IDLE; clear_busy falls after that edge.
  - clear_busy is therefore high for exactly DEPTH cycles after reset release.
- FSM IDLE: normal operation; stays in IDLE until the next reset.
- Requests during CLEARING: write_enable and read_enable are ignored. No array update, no read_valid.
- Reset mid-clear restarts the clear from address 0.
- Write (IDLE, write_enable = 1): for each lane i with write_byte_enable[i] = 1, the word at address gets bits [i*BYTE_WIDTH +: BYTE_WIDTH] from write_data. Other lanes are unchanged. An all-zero mask means no change.
- Read (IDLE, read_enable = 1, sampled at edge N):
  - read_data updates and read_valid is high after edge N+READ_LATENCY-1. READ_LATENCY = 1 matches the legacy RAM timing.
  - Fully pipelined, one request accepted per cycle; responses come back in request order.
  - read_valid is high for exactly one cycle per request.
  - read_data holds its last value when read_valid = 0.
- Read and write in the same cycle (same address by construction):
  - WRITE_FIRST = 0: response is the pre-write word.
  - WRITE_FIRST = 1: response is the merged word (enabled lanes new, others old).
- Address >= DEPTH (non-power-of-two DEPTH): write ignored; read returns a 0 response with read_valid asserted normally.
- Request during reset: discarded.

Optional Feature:
Macro: SINGLE_PORT_RAM_PIPELINED_PARITY_EN
- Defined:
  - Each byte lane stores one extra even-parity bit, computed from the written byte on every write, including clear writes.
  - On read, parity is rechecked across all lanes. read_parity_error goes high together with read_valid if any lane mismatches, for that response only.
- Undefined:
  - No parity storage.
  - read_parity_error is tied to 0.

Test Plan:
- Clear sequence: DEPTH = 64; release resetn; hold requests every cycle -> clear_busy high exactly 64 cycles, read_valid stays 0. Then read all 64 addresses -> all 0x00000000.
- Byte mask: write 0x11223344 mask 4'b1111 to addr 5, then 0xAABBCCDD mask 4'b0101 to addr 5; read addr 5 -> 0x11BB33DD.
- Latency: READ_LATENCY = 3; addrs 0..3 preloaded 0xA0..0xA3; read them back-to-back at edges N..N+3 -> read_valid high after edges N+2..N+5 with 0xA0..0xA3 in order, low afterwards.
- Read-during-write: addr 7 holds 0x00000000; write 0xFFFFFFFF with mask 4'b0011 and read addr 7 in the same cycle -> WRITE_FIRST = 0 returns 0x00000000, WRITE_FIRST = 1 returns 0x0000FFFF. A follow-up read returns 0x0000FFFF in both modes.
- Reset mid-clear: pull resetn low at clear counter 20 -> outputs reset immediately. After release, clear_busy is high 64 full cycles; a write to addr 3 during the clear is lost and reads 0.
- Parity (macro defined): write 0x12345678 to addr 9; force-flip bit 12 in the array; read addr 9 -> read_valid = 1, read_parity_error = 1. Same test with macro undefined -> read_parity_error = 0.
